shift_edge_detect: RTL and testbench



---
 rtl/shift_edge_pkg.sv | 21 ++
 rtl/shift_edge_chan.sv | 99 +++++++++
 rtl/shift_edge_detect.sv | 42 ++++
 tb/tb_shift_edge_detect.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/shift_edge_pkg.sv
// rtl/shift_edge_pkg.sv - shared state encoding, counter width helper and parameter checks
package shift_edge_pkg;

  // Per-channel debounce state, implied by whether the counter is running
  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } chan_state_t;

  // Counter must be able to hold DEBOUNCE itself
  function automatic int cnt_width(input int debounce);
    return (debounce < 1) ? 1 : $clog2(debounce + 1);
  endfunction

  // Legal build: at least one channel, two sync flops, one stable cycle
  function automatic bit params_ok(input int channels, input int sync_stages,
                                   input int debounce);
    return (channels >= 1) && (sync_stages >= 2) && (debounce >= 1);
  endfunction

endpackage

// File: rtl/shift_edge_chan.sv
// rtl/shift_edge_chan.sv - one conditioned input: sync chain, debounce, edge pulses, sticky flag
module shift_edge_chan
  import shift_edge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       signal,
  input  logic       clr,
  output logic [1:0] val,
  output logic       level,
  output logic       rise,
  output logic       fall,
  output logic       o_event
);

  localparam int            CW   = cnt_width(DEBOUNCE);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_prev;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_event;
  logic                   w_s;
  chan_state_t            w_state;

  assign w_s     = r_sync[SYNC_STAGES-1];
  assign w_state = (r_cnt != '0) ? ST_PENDING : ST_STABLE;

  // Synchroniser chain plus one extra sample of history for val
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_s_prev <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], signal};
      r_s_prev <= w_s;
    end
  end

  // Debounce FSM: level flips only after DEBOUNCE consecutive disagreeing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (w_state)
        ST_STABLE: begin
          if (w_s != r_level) begin
            if (LAST == '0) begin
              r_level <= w_s;
              r_rise  <= w_s;
              r_fall  <= ~w_s;
            end else begin
              r_cnt <= CW'(1);
            end
          end
        end
        default: begin
          if (w_s == r_level) begin
            r_cnt <= '0;
          end else if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_level <= w_s;
            r_rise  <= w_s;
            r_fall  <= ~w_s;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  // Sticky flag follows the registered pulses; a new pulse beats a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_event <= 1'b0;
    end else begin
      r_event <= r_rise | r_fall | (r_event & ~clr);
    end
  end

  assign val     = {r_s_prev, w_s};
  assign level   = r_level;
  assign rise    = r_rise;
  assign fall    = r_fall;
  assign o_event = r_event;

endmodule

// File: rtl/shift_edge_detect.sv
// rtl/shift_edge_detect.sv - multi-channel input conditioner built from independent channels
module shift_edge_detect
  import shift_edge_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CHANNELS-1:0]   signal,
  input  logic [CHANNELS-1:0]   clr,
  output logic [2*CHANNELS-1:0] val,
  output logic [CHANNELS-1:0]   level,
  output logic [CHANNELS-1:0]   rise,
  output logic [CHANNELS-1:0]   fall,
  output logic [CHANNELS-1:0]   o_event
);

  if (!params_ok(CHANNELS, SYNC_STAGES, DEBOUNCE)) begin : g_param_check
    $error("shift_edge_detect: illegal CHANNELS/SYNC_STAGES/DEBOUNCE");
  end

  // One channel per input bit, outputs packed channel-major
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    shift_edge_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE   (DEBOUNCE)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .signal (signal[i]),
      .clr    (clr[i]),
      .val    (val[2*i +: 2]),
      .level  (level[i]),
      .rise   (rise[i]),
      .fall   (fall[i]),
      .o_event(o_event[i])
    );
  end

endmodule

// File: tb/tb_shift_edge_detect.sv
// tb/tb_shift_edge_detect.sv - directed self-checking bench for shift_edge_detect
`timescale 1ns/100ps
module tb_shift_edge_detect;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] signal, clr;
  logic [7:0] val;
  logic [3:0] level, rise, fall, ev;

  logic [3:0] nf_signal, nf_clr;
  logic [7:0] nf_val;
  logic [3:0] nf_level, nf_rise, nf_fall, nf_ev;

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] seen;

  always #2 clk = ~clk;

  shift_edge_detect dut (
    .clk(clk), .rst_n(rst_n), .signal(signal), .clr(clr), .val(val),
    .level(level), .rise(rise), .fall(fall), .o_event(ev)
  );

  shift_edge_detect #(.CHANNELS(4), .SYNC_STAGES(3), .DEBOUNCE(1)) dut_nf (
    .clk(clk), .rst_n(rst_n), .signal(nf_signal), .clr(nf_clr), .val(nf_val),
    .level(nf_level), .rise(nf_rise), .fall(nf_fall), .o_event(nf_ev)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; signal = 4'hF; clr = 4'h0;
    nf_signal = 4'h0; nf_clr = 4'h0;

    // 1: reset with inputs high
    step(2);
    chk("rst_val",   {24'd0, val}, 32'h00);
    chk("rst_level", {28'd0, level}, 32'h0);
    chk("rst_rise",  {28'd0, rise | fall}, 32'h0);
    chk("rst_event", {28'd0, ev}, 32'h0);
    rst_n = 1'b1;
    step(1); chk("t1_val_e1", {24'd0, val}, 32'h00);
    step(1); chk("t1_val_e2", {24'd0, val}, 32'h55);
    step(1); chk("t1_val_e3", {24'd0, val}, 32'hFF);
    step(2); chk("t1_rise_e5", {28'd0, rise}, 32'h0);
    chk("t1_level_e5", {28'd0, level}, 32'h0);
    step(1); chk("t1_rise_e6", {28'd0, rise}, 32'hF);
    chk("t1_level_e6", {28'd0, level}, 32'hF);
    step(1); chk("t1_rise_e7", {28'd0, rise}, 32'h0);
    chk("t1_event_e7", {28'd0, ev}, 32'hF);
    chk("t1_level_e7", {28'd0, level}, 32'hF);

    // asynchronous reset takes effect between edges
    signal = 4'h0; rst_n = 1'b0;
    #0.5;
    chk("async_level", {28'd0, level}, 32'h0);
    chk("async_event", {28'd0, ev}, 32'h0);
    step(2); rst_n = 1'b1; step(3);

    // 2: glitch rejection on channel 0
    signal = 4'h1;
    step(2); chk("t2_val_e2", {30'd0, val[1:0]}, 32'h1);
    step(1); chk("t2_val_e3", {30'd0, val[1:0]}, 32'h3);
    signal = 4'h0;
    seen = 4'h0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      seen |= rise | fall;
      if (i == 1) chk("t2_val_e5", {30'd0, val[1:0]}, 32'h2);
    end
    chk("t2_no_pulse", {28'd0, seen}, 32'h0);
    chk("t2_level", {28'd0, level}, 32'h0);
    chk("t2_event", {28'd0, ev}, 32'h0);

    // 3: clean step on channel 1
    signal = 4'h2;
    step(5); chk("t3_rise_e5", {28'd0, rise}, 32'h0);
    step(1); chk("t3_rise_e6", {28'd0, rise}, 32'h2);
    chk("t3_level_e6", {28'd0, level}, 32'h2);
    step(1); chk("t3_event_e7", {28'd0, ev}, 32'h2);
    chk("t3_rise_e7", {28'd0, rise}, 32'h0);
    step(13);
    signal = 4'h0;
    step(5); chk("t3_fall_e5", {28'd0, fall}, 32'h0);
    chk("t3_lvl_hold", {28'd0, level}, 32'h2);
    step(1); chk("t3_fall_e6", {28'd0, fall}, 32'h2);
    chk("t3_level_low", {28'd0, level}, 32'h0);
    step(1); chk("t3_fall_e7", {28'd0, fall}, 32'h0);
    chk("t3_event_kept", {28'd0, ev}, 32'h2);
    clr = 4'h2;
    step(1); chk("t3_event_clr", {28'd0, ev}, 32'h0);
    clr = 4'h0;

    // 4: set beats clear, then clear works one cycle later
    signal = 4'h4;
    step(6); chk("t4_rise", {28'd0, rise}, 32'h4);
    clr = 4'h4;
    step(1); chk("t4_set_wins", {28'd0, ev}, 32'h4);
    step(1); chk("t4_clr_later", {28'd0, ev}, 32'h0);
    clr = 4'h0;
    step(1); chk("t4_clr_idle", {28'd0, ev}, 32'h0);

    // 5: reset while channel 3 counts (counter = 2 after edge 4)
    signal = 4'hC;
    step(4);
    chk("t5_pre_level", {28'd0, level}, 32'h4);
    rst_n = 1'b0;
    #0.5;
    chk("t5_rst_level", {28'd0, level}, 32'h0);
    chk("t5_rst_val",   {24'd0, val}, 32'h00);
    chk("t5_rst_pulse", {28'd0, rise | fall | ev}, 32'h0);
    signal = 4'h0;
    step(2); rst_n = 1'b1;
    seen = 4'h0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      seen |= rise | fall;
    end
    chk("t5_no_pulse", {28'd0, seen}, 32'h0);
    chk("t5_level", {28'd0, level}, 32'h0);

    // 6: no-filter build, SYNC_STAGES=3, DEBOUNCE=1
    nf_signal = 4'h1;
    step(3); chk("t6_rise_e3", {28'd0, nf_rise}, 32'h0);
    step(1); chk("t6_rise_e4", {28'd0, nf_rise}, 32'h1);
    chk("t6_level_e4", {28'd0, nf_level}, 32'h1);
    nf_signal = 4'h0;
    step(4); chk("t6_fall_step", {28'd0, nf_fall}, 32'h1);
    step(3);
    nf_signal = 4'h1;
    step(1);
    nf_signal = 4'h0;
    step(3); chk("t6_pulse_rise", {28'd0, nf_rise}, 32'h1);
    step(1); chk("t6_pulse_fall", {28'd0, nf_fall}, 32'h1);
    chk("t6_pulse_rise_off", {28'd0, nf_rise}, 32'h0);
    chk("t6_main_quiet", {28'd0, level | rise | fall}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
